// File: rtl/wb_ps2_rx.sv
// PS/2 keyboard receiver on a Wishbone slave port: filters the pins, deframes scan codes, buffers them in a FIFO.
// Latency: bus ack one cycle after stb&cyc; a byte is visible in STATUS/DATA one cycle after its stop-bit tick.
// Backpressure: none toward the keyboard; a frame arriving with the FIFO full is dropped and flagged as overrun.
module wb_ps2_rx #(
  parameter int clk_freq       = 100000000,
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic        intr,
  input  logic        ps2_clk,
  input  logic        ps2_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int FLT_W = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Pin conditioning
  logic             clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic             dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic             clk_filt_q, clk_filt_d, dat_filt_q, dat_filt_d;
  logic [FLT_W-1:0] clk_cnt_q, clk_cnt_d, dat_cnt_q, dat_cnt_d;
  logic             tick;

  // Receive FSM
  state_t           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             pbit_q, pbit_d;
  logic [31:0]      to_cnt_q, to_cnt_d;
  logic             push_req, set_frm, set_par;

  // FIFO
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             not_empty, full, push, pop, set_ovr;
  logic [7:0]       head;

  // Registers and bus
  logic             rx_en_q, rx_en_d, irq_en_q, irq_en_d;
  logic             ovr_err_q, ovr_err_d, par_err_q, par_err_d, frm_err_q, frm_err_d;
  logic             ack_q, ack_d, intr_q, intr_d;
  logic [31:0]      dat_o_q, dat_o_d, rd_val;
  logic             acc, clr_w;

  // Bits of the bus that carry no meaning for this block
  logic unused_bits;
  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:5], 32'(clk_freq)};

  assign wb_ack_o  = ack_q;
  assign wb_dat_o  = dat_o_q;
  assign intr      = intr_q;
  assign not_empty = (count_q != '0);
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign head      = mem_q[rd_ptr_q];

  // Two-flop synchronisers, then a glitch filter that only follows a run of FILTER_LEN differing samples
  always_comb begin
    clk_s1_d   = ps2_clk;
    clk_s2_d   = clk_s1_q;
    dat_s1_d   = ps2_data;
    dat_s2_d   = dat_s1_q;
    clk_filt_d = clk_filt_q;
    clk_cnt_d  = '0;
    dat_filt_d = dat_filt_q;
    dat_cnt_d  = '0;
    if (clk_s2_q != clk_filt_q) begin
      if (clk_cnt_q == FLT_W'(FILTER_LEN - 1)) clk_filt_d = clk_s2_q;
      else                                     clk_cnt_d  = clk_cnt_q + 1'b1;
    end
    if (dat_s2_q != dat_filt_q) begin
      if (dat_cnt_q == FLT_W'(FILTER_LEN - 1)) dat_filt_d = dat_s2_q;
      else                                     dat_cnt_d  = dat_cnt_q + 1'b1;
    end
    tick = clk_filt_q & ~clk_filt_d;
  end

  // Frame deserialiser with inactivity timeout; resolves each frame on the stop-bit tick
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    pbit_d    = pbit_q;
    to_cnt_d  = '0;
    push_req  = 1'b0;
    set_frm   = 1'b0;
    set_par   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick && !dat_filt_q && rx_en_q) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d   = {dat_filt_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (tick) begin
          pbit_d  = dat_filt_q;
          state_d = S_STOP;
        end
      end
      default: begin
        if (tick) begin
          state_d = S_IDLE;
          if (!dat_filt_q)               set_frm  = 1'b1;
          else if (!(^{shift_q, pbit_q})) set_par  = 1'b1;
          else                           push_req = 1'b1;
        end
      end
    endcase
    // A stalled keyboard must not wedge the receiver mid-frame
    if (state_q != S_IDLE && !tick) begin
      if (to_cnt_q == 32'(TIMEOUT_CYCLES)) begin
        state_d = S_IDLE;
        set_frm = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 32'd1;
      end
    end
  end

  // Bus decode, register file, FIFO bookkeeping and interrupt
  always_comb begin
    acc   = wb_stb_i & wb_cyc_i & ~ack_q;
    ack_d = acc;
    clr_w = acc & wb_we_i & (wb_adr_i[3:2] == 2'd1);
    pop   = acc & ~wb_we_i & (wb_adr_i[3:2] == 2'd0) & not_empty;

    case (wb_adr_i[3:2])
      2'd0:    rd_val = not_empty ? {23'b0, 1'b1, head} : 32'b0;
      2'd1:    rd_val = {16'b0, 8'(count_q), 3'b0, frm_err_q, par_err_q, ovr_err_q, full, not_empty};
      2'd2:    rd_val = {30'b0, irq_en_q, rx_en_q};
      default: rd_val = 32'b0;
    endcase
    dat_o_d = (acc && !wb_we_i) ? rd_val : 32'b0;

    rx_en_d  = rx_en_q;
    irq_en_d = irq_en_q;
    if (acc && wb_we_i && wb_adr_i[3:2] == 2'd2) begin
      rx_en_d  = wb_dat_i[0];
      irq_en_d = wb_dat_i[1];
    end

    // A simultaneous pop frees the slot, so a full FIFO still accepts the byte
    push    = push_req & (~full | pop);
    set_ovr = push_req & full & ~pop;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Setting wins over a same-cycle W1C clear
    ovr_err_d = (ovr_err_q & ~(clr_w & wb_dat_i[2])) | set_ovr;
    par_err_d = (par_err_q & ~(clr_w & wb_dat_i[3])) | set_par;
    frm_err_d = (frm_err_q & ~(clr_w & wb_dat_i[4])) | set_frm;

    intr_d = irq_en_q & (not_empty | ovr_err_q | par_err_q | frm_err_q);
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1_q   <= 1'b0;
      clk_s2_q   <= 1'b0;
      dat_s1_q   <= 1'b0;
      dat_s2_q   <= 1'b0;
      clk_filt_q <= 1'b1;
      dat_filt_q <= 1'b1;
      clk_cnt_q  <= '0;
      dat_cnt_q  <= '0;
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      pbit_q     <= 1'b0;
      to_cnt_q   <= '0;
      mem_q      <= '{default: 8'h00};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rx_en_q    <= 1'b1;
      irq_en_q   <= 1'b0;
      ovr_err_q  <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      ack_q      <= 1'b0;
      dat_o_q    <= '0;
      intr_q     <= 1'b0;
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      clk_filt_q <= clk_filt_d;
      dat_filt_q <= dat_filt_d;
      clk_cnt_q  <= clk_cnt_d;
      dat_cnt_q  <= dat_cnt_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      pbit_q     <= pbit_d;
      to_cnt_q   <= to_cnt_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rx_en_q    <= rx_en_d;
      irq_en_q   <= irq_en_d;
      ovr_err_q  <= ovr_err_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      ack_q      <= ack_d;
      dat_o_q    <= dat_o_d;
      intr_q     <= intr_d;
    end
  end

endmodule

// File: tb/tb_wb_ps2_rx.sv
// Bench for wb_ps2_rx: directed register/frame scenarios, then random frames against a queue model.
// Latency: every bus access is expected to be acked exactly one cycle after strobe.
// Backpressure: the model drops bytes arriving at a full FIFO and raises overrun.
module tb_wb_ps2_rx;

  localparam int TO    = 2000;
  localparam int FLEN  = 64;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o, intr;
  logic [3:0]  wb_sel_i;
  logic        ps2_clk, ps2_data;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Reference model state
  logic [7:0] mq[$];
  logic       m_ovr = 1'b0, m_par = 1'b0, m_frm = 1'b0;

  always #5 clk = ~clk;

  wb_ps2_rx #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_ack_o(wb_ack_o), .intr(intr),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // One Wishbone access; returns read data plus intr at the ack cycle and one cycle later
  task automatic wb_xfer(input logic we, input logic [1:0] idx, input logic [31:0] wdat,
                         output logic [31:0] rdat, output logic intr_ack, output logic intr_nxt);
    int n;
    @(posedge clk); #1;
    wb_adr_i = {28'h7000000, idx, 2'b00};
    wb_dat_i = wdat;
    wb_we_i  = we;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (wb_ack_o !== 1'b1 && n < 4);
    rdat     = wb_dat_o;
    intr_ack = intr;
    chk("ack_latency", 32'(n), 32'd1);
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
    @(posedge clk); #1;
    intr_nxt = intr;
    chk("ack_single", {31'b0, wb_ack_o}, 32'd0);
    chk("dat_idle", wb_dat_o, 32'd0);
  endtask

  task automatic rd(input logic [1:0] idx, output logic [31:0] r);
    logic a, b;
    wb_xfer(1'b0, idx, 32'd0, r, a, b);
  endtask

  task automatic wr(input logic [1:0] idx, input logic [31:0] d);
    logic [31:0] r;
    logic a, b;
    wb_xfer(1'b1, idx, d, r, a, b);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input int kind);
    logic p, s;
    p = (kind == 1) ? (^b) : ~(^b);
    s = (kind == 2) ? 1'b0 : 1'b1;
    return {s, p, b, 1'b0};
  endfunction

  // Device-side bit clocking: data changes mid-high, 100-cycle low and high phases
  task automatic send_raw(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (50) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (100) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (50) @(posedge clk);
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int kind);
    send_raw(mk_frame(b, kind), 11);
    repeat (20) @(posedge clk);
  endtask

  // kind: 0 good, 1 parity error, 2 framing error
  task automatic model_rx(input logic [7:0] b, input int kind);
    if (kind == 2)                m_frm = 1'b1;
    else if (kind == 1)           m_par = 1'b1;
    else if (mq.size() == DEPTH)  m_ovr = 1'b1;
    else                          mq.push_back(b);
  endtask

  function automatic logic [31:0] exp_status();
    logic [7:0] c;
    c = 8'(mq.size());
    return {16'b0, c, 3'b0, m_frm, m_par, m_ovr, (mq.size() == DEPTH), (mq.size() != 0)};
  endfunction

  task automatic model_pop(output logic [31:0] e);
    if (mq.size() == 0) e = 32'd0;
    else                e = {23'b0, 1'b1, mq.pop_front()};
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, e;
    logic        ia, inx;
    logic [7:0]  b;
    int          kind;

    rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    wb_adr_i = '0; wb_dat_i = '0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0; wb_sel_i = 4'hf;
    repeat (5) @(posedge clk); #1;
    chk("por_ack", {31'b0, wb_ack_o}, 32'd0);
    chk("por_intr", {31'b0, intr}, 32'd0);
    chk("por_dat", wb_dat_o, 32'd0);
    rst = 1'b1;
    repeat (5) @(posedge clk);

    // Reset asserted in the middle of a frame, with a strobe held
    send_raw(mk_frame(8'h55, 0), 4);
    #2 rst = 1'b0;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_ack", {31'b0, wb_ack_o}, 32'd0);
    chk("rst_intr", {31'b0, intr}, 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    rd(2'd1, r); chk("rst_status", r, 32'h0);
    rd(2'd2, r); chk("rst_ctrl", r, 32'h1);

    // Single good frame
    send_frame(8'h1C, 0);
    rd(2'd1, r); chk("one_status", r, 32'h101);
    rd(2'd0, r); chk("one_data", r, 32'h11C);
    rd(2'd1, r); chk("one_status_after", r, 32'h000);
    rd(2'd0, r); chk("empty_data", r, 32'h000);
    wr(2'd0, 32'hFF);
    rd(2'd1, r); chk("data_write_ignored", r, 32'h000);

    // Overflow: nine frames into eight slots
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0);
    rd(2'd1, r); chk("ovf_status", r, 32'h807);
    for (int i = 1; i <= 8; i++) begin
      rd(2'd0, r); chk("ovf_data", r, 32'h100 | 32'(i));
    end
    rd(2'd1, r); chk("ovf_status_drained", r, 32'h004);
    wr(2'd1, 32'h04);
    rd(2'd1, r); chk("ovr_clear", r, 32'h000);

    // Parity error
    send_frame(8'h1C, 1);
    rd(2'd1, r); chk("par_status", r, 32'h008);
    wr(2'd1, 32'h08);
    rd(2'd1, r); chk("par_clear", r, 32'h000);

    // Framing error from a missing stop bit
    send_frame(8'hA5, 2);
    rd(2'd1, r); chk("stop_status", r, 32'h010);
    wr(2'd1, 32'h10);

    // Timeout of a partial frame, then recovery
    send_raw(mk_frame(8'h5A, 0), 4);
    repeat (TO + 500) @(posedge clk);
    rd(2'd1, r); chk("to_status", r, 32'h010);
    wr(2'd1, 32'h10);
    send_frame(8'h5A, 0);
    rd(2'd1, r); chk("to_recover_status", r, 32'h101);
    rd(2'd0, r); chk("to_recover_data", r, 32'h15A);

    // Receiver disabled: new frames are ignored
    wr(2'd2, 32'h0);
    send_frame(8'h33, 0);
    rd(2'd1, r); chk("rxdis_status", r, 32'h000);

    // Interrupt path
    wr(2'd2, 32'h3);
    rd(2'd2, r); chk("ctrl_rw", r, 32'h3);
    send_raw(mk_frame(8'h29, 0), 10);
    repeat (20) @(posedge clk); #1;
    chk("intr_before_stop", {31'b0, intr}, 32'd0);
    send_raw(mk_frame(8'h29, 0) >> 10, 1);
    repeat (20) @(posedge clk); #1;
    chk("intr_set", {31'b0, intr}, 32'd1);
    rd(2'd1, r); chk("intr_status", r, 32'h101);
    wb_xfer(1'b0, 2'd0, 32'd0, r, ia, inx);
    chk("intr_data", r, 32'h129);
    chk("intr_at_pop", {31'b0, ia}, 32'd1);
    chk("intr_after_pop", {31'b0, inx}, 32'd0);

    // Short clock glitch while data is low must not start a frame
    ps2_data = 1'b0;
    repeat (100) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (40) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (100) @(posedge clk);
    ps2_data = 1'b1;
    repeat (TO + 500) @(posedge clk); #1;
    chk("glitch_intr", {31'b0, intr}, 32'd0);
    rd(2'd1, r); chk("glitch_status", r, 32'h000);

    // Random frames against the queue model, irq_en still set
    for (int i = 0; i < 8; i++) begin
      b    = 8'($urandom);
      kind = $urandom_range(0, 5);
      kind = (kind == 0) ? 1 : (kind == 1) ? 2 : 0;
      send_frame(b, kind);
      model_rx(b, kind);
      rd(2'd1, r); chk("rnd_status", r, exp_status());
      chk("rnd_intr", {31'b0, intr}, {31'b0, (mq.size() != 0) | m_ovr | m_par | m_frm});
      if ($urandom_range(0, 1) == 1) begin
        rd(2'd0, r); model_pop(e); chk("rnd_data", r, e);
      end
      if ($urandom_range(0, 2) == 0) begin
        e = 32'($urandom_range(0, 7)) << 2;
        wr(2'd1, e);
        if (e[2]) m_ovr = 1'b0;
        if (e[3]) m_par = 1'b0;
        if (e[4]) m_frm = 1'b0;
        rd(2'd1, r); chk("rnd_w1c", r, exp_status());
      end
    end
    while (mq.size() != 0) begin
      rd(2'd0, r); model_pop(e); chk("rnd_drain", r, e);
    end
    rd(2'd0, r); chk("rnd_empty", r, 32'h0);
    rd(2'd3, r); chk("reg3_zero", r, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_ps2_rx.md
Name: wb_ps2_rx

Overview:
Wishbone slave that receives PS/2 keyboard scan codes for the game front-end and buffers them for the LM32. It connects to a free conbus slave port, for example 0x70000000. Incoming frames are filtered, checked, and pushed into a FIFO. The CPU pops bytes through a data register, and an interrupt line drives one intr_n bit.

Parameters:
clk_freq, 100000000, system clock in Hz; used only to document TIMEOUT_CYCLES
FIFO_DEPTH, 8, receive FIFO entries; must be a power of 2, minimum 2
FILTER_LEN, 8, consecutive equal samples needed before the filtered ps2_clk changes
TIMEOUT_CYCLES, 200000, idle cycles inside a frame before it is aborted (2 ms at 100 MHz)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
wb_adr_i  in  32  byte address; only [3:2] are decoded
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  cycle
wb_we_i  in  1  write enable
wb_sel_i  in  4  byte select; ignored, all accesses are treated as 32-bit
wb_ack_o  out  1  acknowledge
intr  out  1  interrupt, active-high, level
ps2_clk  in  1  PS/2 clock from the pin, asynchronous
ps2_data  in  1  PS/2 data from the pin, asynchronous

Behaviour:
- Reset: one clock; rst is asynchronous and active-low.
  - On rst low, all flops clear immediately.
  - wb_ack_o=0, wb_dat_o=0, intr=0.
  - FIFO empty, error flags 0, FSM in IDLE.
  - CTRL = 0x1 (rx_en=1, irq_en=0).
  - Filtered clock and data are preset to 1.
- Wishbone handshake:
  - wb_ack_o is registered: ack <= stb & cyc & ~ack.
  - Every access sees exactly one ack, one cycle after stb&cyc.
  - Ack never stays high for two consecutive cycles.
  - wb_dat_o is valid in the ack cycle and 0 otherwise.
  - Side effects (pop, clear) happen once, in the cycle ack is set.
- Register map (adr[3:2]):
  - 0 DATA (R): [7:0] = FIFO head, [8] = 1 if the FIFO was non-empty. A read pops the head. Reading when empty returns 0 with no effect. Writes are ignored.
  - 1 STATUS (R): [0] not_empty, [1] full, [2] overrun, [3] parity_err, [4] frame_err, [15:8] count. Writing 1 to bits [4:2] clears them (W1C); other bits are ignored.
  - 2 CTRL (RW): [0] rx_en, [1] irq_en.
  - 3: reads 0; writes are ignored.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchroniser.
  - The filtered value changes only after FILTER_LEN consecutive equal synchronised samples.
  - A sample tick is the filtered clock going 1->0, using data's filtered value at that instant.
- Receive FSM:
  - IDLE: a tick with data=0 and rx_en=1 -> DATA, with bit counter=0. A tick with data=1 stays in IDLE.
  - DATA: shift data in LSB first. After the 8th tick -> PARITY.
  - PARITY: capture the bit -> STOP.
  - STOP: on the tick, return to IDLE and resolve the frame:
    - stop bit = 0 -> set frame_err, discard the byte;
    - else if the XOR of the 8 data bits and the parity bit is 0 (even overall) -> set parity_err, discard;
    - else push the byte. If the FIFO is full, drop the new byte, keep the old contents, and set overrun.
- Timeout: in any state other than IDLE, a 32-bit counter counts cycles since the last tick. When it reaches TIMEOUT_CYCLES -> IDLE, set frame_err, discard the partial byte.
- rx_en cleared mid-frame: the frame in progress completes normally; only new start bits are ignored.
- FIFO:
  - Pointer width is log2(FIFO_DEPTH); count width is log2(FIFO_DEPTH)+1.
  - Pointers wrap around.
  - Push and pop in the same cycle: both happen and count is unchanged. This also applies when full: the pop frees a slot, so the push is accepted and overrun is not set.
  - Pop when empty: no effect.
- Interrupt:
  - intr = irq_en & (not_empty | overrun | parity_err | frame_err), registered, one cycle latency.
  - intr stays high until the condition clears.
- An error flag set and a W1C clear in the same cycle: the set wins.

Test Plan:
- Reset: hold rst=0 mid-frame -> ack=0, intr=0; after release, STATUS reads 0x0 and CTRL reads 0x1.
- Send frame 0x1C with correct odd parity (parity bit 0), PS/2 clock period 60 us -> STATUS=0x101; DATA read returns 0x11C; then STATUS=0x000 and DATA reads 0x000.
- Send 9 good frames 0x01..0x09 without reading, FIFO_DEPTH=8 -> STATUS=0x0807 (count 8, full, overrun, not_empty). Eight DATA reads return 0x101..0x108 in order; 0x09 is lost.
- Send 0x1C with parity bit 1 -> parity_err set, FIFO empty. Write STATUS=0x08 -> STATUS reads 0x00.
- Send a start bit plus 3 data bits, then stop clocking for more than TIMEOUT_CYCLES -> frame_err=1, FSM back in IDLE. A following good frame 0x5A is received correctly.
- Set CTRL=0x3, send 0x29 -> intr rises 1 cycle after not_empty. A DATA read returns 0x129 and intr falls on the next cycle. A 40-cycle glitch on ps2_clk (shorter than FILTER_LEN) produces no tick.
